mem_cmd_sequencer: RTL and testbench

//  Sits between the switch/key IO front end and the SDRAM controller. Accepts one

---
 rtl/mem_cmd_sequencer_if.sv | 32 +++
 rtl/mem_cmd_sequencer.sv | 140 ++++++++++++++
 tb/tb_mem_cmd_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_cmd_sequencer_if.sv
// Command/memory handshake bundle between the IO front end, the sequencer and the SDRAM controller.
// master = sequencer side, slave = front end / controller side.
interface mem_cmd_sequencer_if;
    logic        io_start;
    logic [1:0]  io_mode;
    logic [24:0] io_addr;
    logic [15:0] io_wdata;
    logic        mem_req;
    logic        mem_we;
    logic [24:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;
    logic        mem_done;
    logic [15:0] rd_data;
    logic        err_timeout;

    modport master (
        input  io_start, io_mode, io_addr, io_wdata,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rvalid, mem_rdata,
        output mem_done, rd_data, err_timeout
    );

    modport slave (
        output io_start, io_mode, io_addr, io_wdata,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rvalid, mem_rdata,
        input  mem_done, rd_data, err_timeout
    );
endinterface

// File: rtl/mem_cmd_sequencer.sv
// Sequences one read/write/clear command per start edge onto the memory req/ack handshake.
// Request appears one cycle after entering a request state and is held until acked; start edges while busy are dropped.
module mem_cmd_sequencer #(
    parameter int CLEAR_WORDS    = 1024,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_cmd_sequencer_if.master  bus
);
    localparam int          TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [24:0] LAST_ADDR = 25'(CLEAR_WORDS - 1);
    localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        RD_REQ,
        RD_WAIT,
        CLR_REQ
    } state_t;

    state_t         state;
    logic           startQ;
    logic [24:0]    clrCnt;
    logic [TW-1:0]  toCnt;
    logic           startEdge;
    logic [TW-1:0]  toNext;
    logic [24:0]    clrNext;

    assign startEdge = bus.io_start & ~startQ;
    assign toNext    = toCnt + TW'(1);
    assign clrNext   = clrCnt + 25'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            startQ          <= 1'b0;
            clrCnt          <= '0;
            toCnt           <= '0;
            bus.mem_req     <= 1'b0;
            bus.mem_we      <= 1'b0;
            bus.mem_addr    <= '0;
            bus.mem_wdata   <= '0;
            bus.mem_done    <= 1'b1;
            bus.rd_data     <= '0;
            bus.err_timeout <= 1'b0;
        end else begin
            startQ <= bus.io_start;
            case (state)
                IDLE: begin
                    bus.mem_done <= 1'b1;
                    bus.mem_req  <= 1'b0;
                    // mode 11 is a no-op: nothing latched, error flag untouched
                    if (startEdge && bus.io_mode != 2'b11) begin
                        bus.mem_done    <= 1'b0;
                        bus.err_timeout <= 1'b0;
                        bus.mem_addr    <= bus.io_addr;
                        bus.mem_wdata   <= bus.io_wdata;
                        case (bus.io_mode)
                            2'b10: begin
                                state      <= WR_REQ;
                                bus.mem_we <= 1'b1;
                            end
                            2'b01: begin
                                state      <= RD_REQ;
                                bus.mem_we <= 1'b0;
                            end
                            default: begin
                                state         <= CLR_REQ;
                                bus.mem_we    <= 1'b1;
                                bus.mem_addr  <= '0;
                                bus.mem_wdata <= '0;
                                clrCnt        <= '0;
                            end
                        endcase
                    end
                end

                WR_REQ: begin
                    if (!bus.mem_req) begin
                        bus.mem_req <= 1'b1;
                    end else if (bus.mem_ack) begin
                        bus.mem_req  <= 1'b0;
                        bus.mem_done <= 1'b1;
                        state        <= IDLE;
                    end
                end

                RD_REQ: begin
                    if (!bus.mem_req) begin
                        bus.mem_req <= 1'b1;
                    end else if (bus.mem_ack) begin
                        bus.mem_req <= 1'b0;
                        toCnt       <= '0;
                        // a response arriving together with the ack completes the read
                        if (bus.mem_rvalid) begin
                            bus.rd_data  <= bus.mem_rdata;
                            bus.mem_done <= 1'b1;
                            state        <= IDLE;
                        end else begin
                            state <= RD_WAIT;
                        end
                    end
                end

                RD_WAIT: begin
                    if (bus.mem_rvalid) begin
                        bus.rd_data  <= bus.mem_rdata;
                        bus.mem_done <= 1'b1;
                        state        <= IDLE;
                    end else if (toNext == TO_LIMIT) begin
                        bus.err_timeout <= 1'b1;
                        bus.mem_done    <= 1'b1;
                        state           <= IDLE;
                    end else begin
                        toCnt <= toNext;
                    end
                end

                CLR_REQ: begin
                    if (!bus.mem_req) begin
                        bus.mem_req <= 1'b1;
                    end else if (bus.mem_ack) begin
                        if (clrCnt == LAST_ADDR) begin
                            bus.mem_req  <= 1'b0;
                            bus.mem_done <= 1'b1;
                            state        <= IDLE;
                        end else begin
                            clrCnt       <= clrNext;
                            bus.mem_addr <= clrNext;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_cmd_sequencer.sv
// Randomized scoreboard bench: stimulus pushes expected transfers/outcomes, a negedge monitor
// plays the memory controller and compares every transfer and every mem_done rise.
module tb_mem_cmd_sequencer;
    localparam int CW = 16;
    localparam int TO = 8;

    typedef struct packed { logic we; logic [24:0] addr; logic [15:0] wdata; } req_t;
    typedef struct packed { logic [15:0] rd; logic err; } res_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_cmd_sequencer_if bus ();

    mem_cmd_sequencer #(.CLEAR_WORDS(CW), .TIMEOUT_CYCLES(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    req_t        reqQ[$];
    res_t        resQ[$];
    int          nCmp    = 0;
    int          nFail   = 0;
    int          ackPct  = 100;
    int          ackHold = 0;
    int          rdDelay = 0;
    logic [15:0] rdPlan  = '0;
    int          rvCnt   = 0;
    logic [15:0] mRd     = '0;
    logic        mErr    = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step;
        @(negedge clk);
        #1;
    endtask

    task automatic chkReset(input string tag);
        check({tag, "_mem_req"},   32'(bus.mem_req),     32'd0);
        check({tag, "_mem_we"},    32'(bus.mem_we),      32'd0);
        check({tag, "_mem_addr"},  32'(bus.mem_addr),    32'd0);
        check({tag, "_mem_wdata"}, 32'(bus.mem_wdata),   32'd0);
        check({tag, "_mem_done"},  32'(bus.mem_done),    32'd1);
        check({tag, "_rd_data"},   32'(bus.rd_data),     32'd0);
        check({tag, "_err"},       32'(bus.err_timeout), 32'd0);
    endtask

    task automatic waitQuiet;
        int g = 0;
        while (!(bus.mem_done && rvCnt == 0 && !bus.mem_rvalid) && g < 400) begin
            step();
            g++;
        end
        if (g >= 400) begin
            nCmp++;
            nFail++;
            $display("FAIL wait_idle: still busy after %0d cycles, required idle", g);
        end
    endtask

    // Expected memory traffic and end-of-command outcome for one command.
    task automatic pushExpect(input logic [1:0] mode, input logic [24:0] addr,
                              input logic [15:0] wd, input int delay, input logic [15:0] rdat);
        case (mode)
            2'b10: begin
                reqQ.push_back('{we: 1'b1, addr: addr, wdata: wd});
                mErr = 1'b0;
                resQ.push_back('{rd: mRd, err: mErr});
            end
            2'b01: begin
                reqQ.push_back('{we: 1'b0, addr: addr, wdata: 16'h0});
                if (delay <= TO) begin
                    mRd  = rdat;
                    mErr = 1'b0;
                end else begin
                    mErr = 1'b1;
                end
                resQ.push_back('{rd: mRd, err: mErr});
            end
            2'b00: begin
                for (int i = 0; i < CW; i++) reqQ.push_back('{we: 1'b1, addr: 25'(i), wdata: 16'h0});
                mErr = 1'b0;
                resQ.push_back('{rd: mRd, err: mErr});
            end
            default: ;
        endcase
    endtask

    task automatic doCmd(input logic [1:0] mode, input logic [24:0] addr,
                         input logic [15:0] wd, input int delay, input logic [15:0] rdat);
        waitQuiet();
        bus.io_start = 1'b0;
        step();
        rdDelay      = delay;
        rdPlan       = rdat;
        bus.io_mode  = mode;
        bus.io_addr  = addr;
        bus.io_wdata = wd;
        pushExpect(mode, addr, wd, delay, rdat);
        bus.io_start = 1'b1;
        step();
        bus.io_addr  = 25'($urandom);
        bus.io_wdata = 16'($urandom);
        bus.io_mode  = 2'($urandom);
        if (mode == 2'b11) begin
            for (int k = 0; k < 4; k++) begin
                check("noop_done", 32'(bus.mem_done), 32'd1);
                check("noop_req",  32'(bus.mem_req),  32'd0);
                step();
            end
        end
    endtask

    // Memory-controller model and scoreboard monitor.
    initial begin : monitor
        logic        prevReq, prevAck, prevDone, prevWe;
        logic [24:0] prevAddr;
        logic [15:0] prevWd;
        int          reqAge;
        req_t        e;
        res_t        r;
        prevReq = 1'b0; prevAck = 1'b0; prevDone = 1'b1; prevWe = 1'b0;
        prevAddr = '0; prevWd = '0; reqAge = 0;
        bus.mem_ack = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                bus.mem_ack    = 1'b0;
                bus.mem_rvalid = 1'b0;
                rvCnt          = 0;
                prevReq        = 1'b0;
                prevAck        = 1'b0;
                prevDone       = 1'b1;
                reqAge         = 0;
            end else begin
                if (prevReq && !prevAck) begin
                    check("req_held",  32'(bus.mem_req),  32'd1);
                    check("hold_we",   32'(bus.mem_we),   32'(prevWe));
                    check("hold_addr", 32'(bus.mem_addr), 32'(prevAddr));
                    if (prevWe) check("hold_wdata", 32'(bus.mem_wdata), 32'(prevWd));
                end
                if (bus.mem_done && !prevDone) begin
                    if (resQ.size() == 0) begin
                        nCmp++;
                        nFail++;
                        $display("FAIL unexpected_done: mem_done rose with no command outstanding at %0t", $time);
                    end else begin
                        r = resQ.pop_front();
                        check("rd_data",       32'(bus.rd_data),     32'(r.rd));
                        check("err_timeout",   32'(bus.err_timeout), 32'(r.err));
                        check("reqs_consumed", 32'(reqQ.size()),     32'd0);
                    end
                end
                prevDone = bus.mem_done;

                bus.mem_rvalid = 1'b0;
                bus.mem_rdata  = 16'($urandom);
                if (rvCnt > 0) begin
                    rvCnt--;
                    if (rvCnt == 0) begin
                        bus.mem_rvalid = 1'b1;
                        bus.mem_rdata  = rdPlan;
                    end
                end

                reqAge = bus.mem_req ? ((prevReq && !prevAck) ? reqAge + 1 : 1) : 0;
                if (ackHold > 0) bus.mem_ack = (reqAge >= ackHold);
                else bus.mem_ack = (ackPct >= 100) || (int'($urandom_range(99, 0)) < ackPct);

                if (bus.mem_req && bus.mem_ack) begin
                    if (reqQ.size() == 0) begin
                        nCmp++;
                        nFail++;
                        $display("FAIL unexpected_req: we=%0d addr=0x%0h with none expected at %0t",
                                 bus.mem_we, bus.mem_addr, $time);
                    end else begin
                        e = reqQ.pop_front();
                        check("xfer_we",   32'(bus.mem_we),   32'(e.we));
                        check("xfer_addr", 32'(bus.mem_addr), 32'(e.addr));
                        if (e.we) check("xfer_wdata", 32'(bus.mem_wdata), 32'(e.wdata));
                    end
                    if (!bus.mem_we) begin
                        if (rdDelay == 0) begin
                            bus.mem_rvalid = 1'b1;
                            bus.mem_rdata  = rdPlan;
                        end else begin
                            rvCnt = rdDelay;
                        end
                    end
                end
                prevReq  = bus.mem_req;
                prevAck  = bus.mem_ack;
                prevWe   = bus.mem_we;
                prevAddr = bus.mem_addr;
                prevWd   = bus.mem_wdata;
            end
        end
    end

    initial begin : stimulus
        int g;
        bus.io_start = 1'b0;
        bus.io_mode  = 2'b11;
        bus.io_addr  = '0;
        bus.io_wdata = '0;
        #2 rst = 1'b1;
        #1 chkReset("rst0");
        repeat (3) step();
        rst = 1'b0;
        step();

        // Directed: write held 3 cycles before ack, read with data, boundary reads.
        ackHold = 3;
        doCmd(2'b10, 25'h1ABCDEF, 16'h5A5A, 0, 16'h0);
        ackHold = 0;
        ackPct  = 100;
        doCmd(2'b01, 25'h0000123, 16'h0, 4, 16'hBEEF);
        doCmd(2'b01, 25'h0000456, 16'h0, 20, 16'hDEAD);
        doCmd(2'b10, 25'h0000010, 16'h1234, 0, 16'h0);
        doCmd(2'b01, 25'h0000777, 16'h0, TO, 16'hCAFE);
        doCmd(2'b01, 25'h0000778, 16'h0, TO + 1, 16'hF00D);
        doCmd(2'b01, 25'h0000779, 16'h0, 0, 16'h0A0A);

        // Start-to-done latency with ack tied high.
        waitQuiet();
        bus.io_start = 1'b0;
        step();
        bus.io_mode  = 2'b10;
        bus.io_addr  = 25'h00ABCDE;
        bus.io_wdata = 16'h7777;
        pushExpect(2'b10, 25'h00ABCDE, 16'h7777, 0, 16'h0);
        bus.io_start = 1'b1;
        g = 0;
        do begin
            step();
            g++;
        end while (!bus.mem_done && g < 20);
        check("wr_latency", 32'(g), 32'd3);

        // Clear at 50% ack.
        ackPct = 50;
        doCmd(2'b00, 25'h0, 16'hFFFF, 0, 16'h0);

        // Start toggled while busy, then held high into IDLE: only the clear runs.
        waitQuiet();
        ackPct = 30;
        bus.io_start = 1'b0;
        step();
        bus.io_mode = 2'b00;
        pushExpect(2'b00, 25'h0, 16'h0, 0, 16'h0);
        bus.io_start = 1'b1;
        step();
        for (int k = 0; k < 6; k++) begin
            bus.io_start = 1'b0;
            step();
            bus.io_mode  = 2'($urandom);
            bus.io_addr  = 25'($urandom);
            bus.io_start = 1'b1;
            step();
        end
        waitQuiet();
        repeat (6) step();
        check("busy_idle_done", 32'(bus.mem_done), 32'd1);
        doCmd(2'b11, 25'h1, 16'h1, 0, 16'h0);

        // Randomized commands.
        for (int n = 0; n < 40; n++) begin
            ackPct = int'($urandom_range(100, 25));
            doCmd(2'($urandom_range(3, 0)), 25'($urandom), 16'($urandom),
                  int'($urandom_range(TO + 3, 0)), 16'($urandom));
        end

        // Reset in the middle of a clear, released with start held high.
        waitQuiet();
        bus.io_start = 1'b0;
        step();
        ackPct = 50;
        bus.io_mode = 2'b00;
        pushExpect(2'b00, 25'h0, 16'h0, 0, 16'h0);
        bus.io_start = 1'b1;
        g = 0;
        while (!(bus.mem_req && bus.mem_addr == 25'd5) && g < 200) begin
            step();
            g++;
        end
        check("reach_clear_addr5", 32'(bus.mem_addr), 32'd5);
        rst = 1'b1;
        #1 chkReset("rst_mid");
        reqQ.delete();
        resQ.delete();
        mRd  = '0;
        mErr = 1'b0;
        bus.io_mode  = 2'b10;
        bus.io_addr  = 25'h0F0F0F0;
        bus.io_wdata = 16'h3C3C;
        pushExpect(2'b10, 25'h0F0F0F0, 16'h3C3C, 0, 16'h0);
        step();
        step();
        rst = 1'b0;
        step();
        step();
        waitQuiet();
        doCmd(2'b01, 25'h0000042, 16'h0, 2, 16'h9999);

        waitQuiet();
        repeat (3) step();
        check("queues_drained", 32'(reqQ.size() + resQ.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end
endmodule
